spi_apb_sequencer: RTL and testbench

//  APB3 master that feeds CORESPI_C1 (8-bit APB, 8-bit frames, master mode). It turns a

---
 rtl/spi_seq_pkg.sv | 31 +++
 rtl/spi_apb_sequencer_if.sv | 21 ++
 rtl/apb_master_port.sv | 56 +++++
 rtl/spi_apb_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_spi_apb_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - CORESPI register map, STAT bits and sequencer state encoding
package spi_seq_pkg;

    localparam logic [6:0] REG_CTRL1  = 7'h00;
    localparam logic [6:0] REG_INTCLR = 7'h04;
    localparam logic [6:0] REG_RXDATA = 7'h08;
    localparam logic [6:0] REG_TXDATA = 7'h0C;
    localparam logic [6:0] REG_STAT   = 7'h20;
    localparam logic [6:0] REG_SSEL   = 7'h24;
    localparam logic [6:0] REG_TXLAST = 7'h28;

    localparam int STAT_RXEMPTY = 2;

    // enable | master
    localparam logic [7:0] CTRL1_INIT = 8'h03;

    // TXWR is split out of WAITTX so the TX byte handshake and the APB write
    // never overlap in the same state.
    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_SSEL,
        S_WAITTX,
        S_TXWR,
        S_POLL,
        S_RXRD,
        S_PUSH,
        S_DESEL
    } seq_state_e;

endpackage

// File: rtl/spi_apb_sequencer_if.sv
// rtl/spi_apb_sequencer_if.sv - APB3 bus between the sequencer and CORESPI
interface spi_apb_sequencer_if;
    logic [6:0] PADDR;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_port.sv
// rtl/apb_master_port.sv - single-access APB3 SETUP/ACCESS sequencer
module apb_master_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [6:0] addr,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       slverr,
    spi_apb_sequencer_if.master apb
);

    logic       psel;
    logic       penable;
    logic [6:0] paddr;
    logic       pwrite;
    logic [7:0] pwdata;

    // Start an access when idle and requested, step SETUP->ACCESS, release on PREADY.
    // The release cycle always leaves PSEL low for a cycle, so a request that is still
    // high from the finishing state can never start a duplicate access.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
        end else if (!psel) begin
            if (req) begin
                psel   <= 1'b1;
                paddr  <= addr;
                pwrite <= wr;
                pwdata <= wdata;
            end
        end else if (!penable) begin
            penable <= 1'b1;
        end else if (apb.PREADY) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    assign ack    = psel && penable && apb.PREADY;
    assign rdata  = apb.PRDATA;
    assign slverr = apb.PSLVERR;

    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PADDR   = paddr;
    assign apb.PWRITE  = pwrite;
    assign apb.PWDATA  = pwdata;

endmodule

// File: rtl/spi_apb_sequencer.sv
// rtl/spi_apb_sequencer.sv - command-driven APB master feeding CORESPI frames
module spi_apb_sequencer
    import spi_seq_pkg::*;
#(
    parameter int LEN_W    = 5,
    parameter int POLL_MAX = 1023
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_ssel,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    spi_apb_sequencer_if.master apb
);

    localparam int POLL_W = $clog2(POLL_MAX + 1);

    seq_state_e        state, state_n;
    logic [7:0]        ssel_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  frame_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [7:0]        tx_q;
    logic [7:0]        rx_q;
    logic              fail_q;
    logic              done_q;
    logic              err_q;
    logic              fail_set;
    logic              last_frame;

    logic              req;
    logic [6:0]        addr;
    logic              wr;
    logic [7:0]        wdata;
    logic              ack;
    logic [7:0]        rdata;
    logic              slverr;

    apb_master_port u_port (
        .clk    (PCLK),
        .rst    (PRESET),
        .req    (req),
        .addr   (addr),
        .wr     (wr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .slverr (slverr),
        .apb    (apb)
    );

    assign last_frame = (frame_cnt == (len_q - LEN_W'(1)));

    // State register; reset always lands in INIT so CTRL1 is rewritten.
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= S_INIT;
        else        state <= state_n;
    end

    // Next state, APB request and stream handshakes.
    always_comb begin
        state_n   = state;
        req       = 1'b0;
        addr      = REG_CTRL1;
        wr        = 1'b1;
        wdata     = 8'h00;
        cmd_ready = 1'b0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        fail_set  = 1'b0;
        case (state)
            S_INIT: begin
                req   = 1'b1;
                wdata = CTRL1_INIT;
                if (ack) state_n = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) state_n = S_SSEL;
            end
            S_SSEL: begin
                req   = 1'b1;
                addr  = REG_SSEL;
                wdata = ssel_q;
                if (ack) begin
                    fail_set = slverr;
                    state_n  = slverr ? S_DESEL : S_WAITTX;
                end
            end
            S_WAITTX: begin
                tx_ready = tx_valid;
                if (tx_valid) state_n = S_TXWR;
            end
            S_TXWR: begin
                req   = 1'b1;
                addr  = last_frame ? REG_TXLAST : REG_TXDATA;
                wdata = tx_q;
                if (ack) begin
                    fail_set = slverr;
                    state_n  = slverr ? S_DESEL : S_POLL;
                end
            end
            S_POLL: begin
                req  = 1'b1;
                wr   = 1'b0;
                addr = REG_STAT;
                if (ack) begin
                    if (slverr) begin
                        fail_set = 1'b1;
                        state_n  = S_DESEL;
                    end else if (!rdata[STAT_RXEMPTY]) begin
                        state_n = S_RXRD;
                    end else if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
                        fail_set = 1'b1;
                        state_n  = S_DESEL;
                    end
                end
            end
            S_RXRD: begin
                req  = 1'b1;
                wr   = 1'b0;
                addr = REG_RXDATA;
                if (ack) begin
                    fail_set = slverr;
                    state_n  = slverr ? S_DESEL : S_PUSH;
                end
            end
            S_PUSH: begin
                rx_valid = 1'b1;
                if (rx_ready) state_n = last_frame ? S_DESEL : S_WAITTX;
            end
            S_DESEL: begin
                req  = 1'b1;
                addr = REG_SSEL;
                if (ack) state_n = S_IDLE;
            end
            default: state_n = S_INIT;
        endcase
    end

    // Command latch, frame/poll counters, data holding registers and end pulses.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ssel_q    <= '0;
            len_q     <= '0;
            frame_cnt <= '0;
            poll_cnt  <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            fail_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_INIT:   if (ack && slverr) err_q <= 1'b1;
                S_IDLE: begin
                    if (cmd_valid) begin
                        ssel_q    <= cmd_ssel;
                        len_q     <= cmd_len;
                        frame_cnt <= '0;
                        fail_q    <= 1'b0;
                        if (cmd_len == '0) done_q <= 1'b1;
                    end
                end
                S_WAITTX: if (tx_valid) tx_q <= tx_data;
                S_TXWR:   poll_cnt <= '0;
                S_POLL:   if (ack) poll_cnt <= poll_cnt + POLL_W'(1);
                S_RXRD:   if (ack) rx_q <= rdata;
                S_PUSH:   if (rx_ready) frame_cnt <= frame_cnt + LEN_W'(1);
                S_DESEL: begin
                    if (ack) begin
                        if (fail_q || slverr) err_q  <= 1'b1;
                        else                  done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (fail_set) fail_q <= 1'b1;
        end
    end

    assign busy    = (state != S_IDLE) && (state != S_INIT);
    assign rx_data = rx_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// tb/tb_spi_apb_sequencer.sv - randomized self-checking bench with CORESPI slave model
module tb_spi_apb_sequencer;
    import spi_seq_pkg::*;

    localparam int LEN_W    = 5;
    localparam int POLL_MAX = 8;

    logic             PCLK = 1'b0;
    logic             PRESET = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [7:0]       cmd_ssel = 8'h00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             tx_valid = 1'b0;
    logic [7:0]       tx_data = 8'h00;
    logic             rx_ready = 1'b0;
    logic             cmd_ready, tx_ready, rx_valid, busy, done, err;
    logic [7:0]       rx_data;

    spi_apb_sequencer_if apb ();

    spi_apb_sequencer #(.LEN_W(LEN_W), .POLL_MAX(POLL_MAX)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ssel  (cmd_ssel),
        .cmd_len   (cmd_len),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .apb       (apb)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ent(input logic w, input logic [6:0] a, input logic [7:0] d);
        return {w, a, d};
    endfunction

    // slave model state
    int         ws = 0;
    int         stat_cnt = 0;
    int         empty_polls = 0;
    bit         stuck = 0;
    bit         err_tx = 0;
    logic [7:0] srxq[$];

    // scoreboard state
    logic [15:0] log_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  txq[$];
    logic [7:0]  rx_got[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  tx_bytes[32];
    logic [7:0]  rx_bytes[32];
    int          done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int          hold_rx = 0, stall_done = 0, stall_log = 0;
    bit          stall_armed = 0;
    logic [7:0]  stall_data = 8'h00;

    // Slave responses, TX source and RX sink, all driven on the falling edge.
    always @(negedge PCLK) begin
        if (apb.PSEL && apb.PENABLE && !PRESET) begin
            if (ws > 0) begin
                apb.PREADY = 1'b0;
                ws--;
            end else begin
                apb.PREADY  = 1'b1;
                apb.PSLVERR = 1'b0;
                apb.PRDATA  = 8'($urandom);
                if (!apb.PWRITE && apb.PADDR == REG_STAT) begin
                    apb.PRDATA[STAT_RXEMPTY] = stuck || (stat_cnt < empty_polls);
                    stat_cnt++;
                end else if (!apb.PWRITE && apb.PADDR == REG_RXDATA) begin
                    apb.PRDATA = (srxq.size() != 0) ? srxq.pop_front() : 8'h00;
                end else if (apb.PWRITE && (apb.PADDR == REG_TXDATA || apb.PADDR == REG_TXLAST)) begin
                    stat_cnt    = 0;
                    apb.PSLVERR = err_tx;
                end
            end
        end else begin
            apb.PREADY  = 1'b0;
            apb.PSLVERR = 1'b0;
            ws = $urandom_range(0, 2);
        end

        tx_valid = (txq.size() != 0) && ($urandom_range(0, 3) != 0);
        tx_data  = tx_valid ? txq[0] : 8'($urandom);

        if (hold_rx > 0 && rx_valid) begin
            rx_ready = 1'b0;
            if (!stall_armed) begin
                stall_armed = 1;
                stall_log   = log_q.size();
                stall_data  = rx_data;
            end
            hold_rx--;
            if (hold_rx == 0) begin
                check("stall_no_apb", log_q.size(), stall_log);
                check("stall_rx_data", 32'(rx_data), 32'(stall_data));
                check("stall_rx_valid", 32'(rx_valid), 32'd1);
                stall_done++;
            end
        end else begin
            rx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Observe completed accesses and handshakes after the falling-edge drive settles.
    always @(negedge PCLK) begin
        #1;
        if (!PRESET) begin
            if (apb.PSEL && apb.PENABLE && apb.PREADY)
                log_q.push_back(ent(apb.PWRITE, apb.PADDR,
                    apb.PWRITE ? apb.PWDATA :
                    (apb.PADDR == REG_STAT) ? (apb.PRDATA & 8'h04) : apb.PRDATA));
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done && err) both_cnt++;
            if (tx_valid && tx_ready && txq.size() != 0) void'(txq.pop_front());
            if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] ssel, input int len, input int polls,
                           input bit stk, input bit etx, input int hold, input string tag);
        int n;
        bit ok;
        stuck = stk; err_tx = etx; empty_polls = polls; stat_cnt = 0;
        srxq.delete(); txq.delete(); exp_q.delete(); exp_rx.delete();
        for (int f = 0; f < len; f++) begin
            txq.push_back(tx_bytes[f]);
            srxq.push_back(rx_bytes[f]);
        end
        ok = 1;
        if (len > 0) begin
            exp_q.push_back(ent(1'b1, REG_SSEL, ssel));
            for (int f = 0; f < len && ok; f++) begin
                exp_q.push_back(ent(1'b1, (f == len - 1) ? REG_TXLAST : REG_TXDATA, tx_bytes[f]));
                if (etx) begin
                    ok = 0;
                end else if (stk) begin
                    for (int p = 0; p < POLL_MAX; p++) exp_q.push_back(ent(1'b0, REG_STAT, 8'h04));
                    ok = 0;
                end else begin
                    for (int p = 0; p < polls; p++) exp_q.push_back(ent(1'b0, REG_STAT, 8'h04));
                    exp_q.push_back(ent(1'b0, REG_STAT, 8'h00));
                    exp_q.push_back(ent(1'b0, REG_RXDATA, rx_bytes[f]));
                    exp_rx.push_back(rx_bytes[f]);
                end
            end
            exp_q.push_back(ent(1'b1, REG_SSEL, 8'h00));
        end

        wait_ready(tag);
        log_q.delete(); rx_got.delete();
        done_cnt = 0; err_cnt = 0; both_cnt = 0;
        stall_done = 0; stall_armed = 0; hold_rx = hold;
        cmd_valid = 1'b1;
        cmd_ssel  = ssel;
        cmd_len   = LEN_W'(len);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (done_cnt + err_cnt == 0 && n < 6000) begin
            @(negedge PCLK);
            n++;
        end
        repeat (4) @(negedge PCLK);

        check({tag, "_finished"}, 32'(done_cnt + err_cnt > 0), 32'd1);
        check({tag, "_log_n"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_log%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        check({tag, "_rx_n"}, rx_got.size(), exp_rx.size());
        for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), 32'(rx_got[i]), 32'(exp_rx[i]));
        check({tag, "_done"}, done_cnt, ok ? 1 : 0);
        check({tag, "_err"}, err_cnt, ok ? 0 : 1);
        check({tag, "_both"}, both_cnt, 0);
        check({tag, "_idle"}, 32'({busy, cmd_ready}), 32'b01);
        if (hold > 0) check({tag, "_stalled"}, stall_done, 1);
        hold_rx = 0; stuck = 0; err_tx = 0;
    endtask

    initial begin
        int n;
        apb.PREADY = 1'b0; apb.PRDATA = 8'h00; apb.PSLVERR = 1'b0;

        // 1: reset state and single CTRL1 write after release
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        check("rst_psel", 32'(apb.PSEL), 32'd0);
        check("rst_penable", 32'(apb.PENABLE), 32'd0);
        check("rst_paddr", 32'(apb.PADDR), 32'd0);
        check("rst_ctl", 32'({cmd_ready, busy, done, err, rx_valid, tx_ready}), 32'd0);
        log_q.delete();
        PRESET = 1'b0;
        wait_ready("init");
        repeat (10) @(negedge PCLK);
        check("init_log_n", log_q.size(), 1);
        if (log_q.size() != 0) check("init_ctrl1", 32'(log_q[0]), 32'(ent(1'b1, REG_CTRL1, 8'h03)));
        check("init_busy", 32'(busy), 32'd0);

        // 2: directed three-frame transfer
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h5A; tx_bytes[2] = 8'hFF;
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
        run_cmd(8'h01, 3, 1, 0, 0, 0, "t2");

        // 3: RX back-pressure for 20 cycles in frame 1
        for (int i = 0; i < 3; i++) begin
            tx_bytes[i] = 8'($urandom); rx_bytes[i] = 8'($urandom);
        end
        run_cmd(8'h04, 3, 0, 0, 0, 20, "t3");

        // 4: RXEMPTY stuck -> poll timeout
        tx_bytes[0] = 8'h77; rx_bytes[0] = 8'h00;
        run_cmd(8'h02, 1, 0, 1, 0, 0, "t4");

        // 5: PSLVERR on TXDATA, then an empty command
        tx_bytes[0] = 8'h9C; tx_bytes[1] = 8'h3E;
        run_cmd(8'h80, 2, 0, 0, 1, 0, "t5");
        run_cmd(8'h10, 0, 0, 0, 0, 0, "t5z");

        // random commands, ending with the longest one
        for (int k = 0; k < 10; k++) begin
            int len;
            len = (k == 9) ? 31 : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                tx_bytes[i] = 8'($urandom); rx_bytes[i] = 8'($urandom);
            end
            run_cmd(8'(1 << $urandom_range(0, 7)), len, $urandom_range(0, 3), 0, 0, 0,
                    $sformatf("rnd%0d", k));
        end

        // 6: reset during a STAT access
        stuck = 1; empty_polls = 0; err_tx = 0; stat_cnt = 0;
        txq.delete(); srxq.delete(); txq.push_back(8'h3C);
        wait_ready("t6");
        cmd_valid = 1'b1; cmd_ssel = 8'h02; cmd_len = LEN_W'(1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!(apb.PSEL && apb.PENABLE && !apb.PWRITE && apb.PADDR == REG_STAT) && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        check("t6_in_poll", 32'(apb.PSEL && apb.PENABLE && apb.PADDR == REG_STAT), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("t6_psel", 32'(apb.PSEL), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(negedge PCLK);
        stuck = 0; txq.delete();
        log_q.delete();
        PRESET = 1'b0;
        wait_ready("t6_rel");
        repeat (4) @(negedge PCLK);
        check("t6_log_n", log_q.size(), 1);
        if (log_q.size() != 0) check("t6_ctrl1", 32'(log_q[0]), 32'(ent(1'b1, REG_CTRL1, 8'h03)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
